// File: rtl/ppt_pkg.sv
// Shared types, widths and config helpers for the PPT controller.
package ppt_pkg;

    localparam int PPT_CLKDIV_W = 5;
    localparam int PPT_PERIOD_W = 15;
    localparam int PPT_COUNT_W  = 8;
    localparam int PPT_PRESC_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DONE = 2'd2
    } ppt_state_e;

    typedef struct packed {
        logic [PPT_CLKDIV_W-1:0] clk_div;
        logic [PPT_PERIOD_W-1:0] period;
        logic [PPT_PERIOD_W-1:0] width;
        logic [PPT_COUNT_W-1:0]  count;
    } ppt_cfg_t;

    function automatic logic [PPT_PERIOD_W-1:0] eff_period(input logic [PPT_PERIOD_W-1:0] p);
        return (p == '0) ? PPT_PERIOD_W'(1) : p;
    endfunction

    function automatic logic [PPT_PERIOD_W-1:0] eff_width(input logic [PPT_PERIOD_W-1:0] w,
                                                          input logic [PPT_PERIOD_W-1:0] p);
        logic [PPT_PERIOD_W-1:0] ep;
        ep = eff_period(p);
        return (w < ep) ? w : ep;
    endfunction

endpackage

// File: rtl/ppt_prescaler.sv
// Tick generator: one-cycle tick every 2^(clk_div+1) clocks, restarted by clear.
module ppt_prescaler
    import ppt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [PPT_CLKDIV_W-1:0] clk_div,
    output logic                    tick
);

    logic [PPT_PRESC_W-1:0] cnt_q;
    logic [PPT_PRESC_W-1:0] cnt_d;
    logic [PPT_PRESC_W-1:0] terminal;

    always_comb begin
        // 2^(clk_div+1)-1 built by shifting ones, so clk_div=31 gives all ones without overflow
        terminal = {PPT_PRESC_W{1'b1}} >> (5'd31 - clk_div);
        tick     = (cnt_q == terminal) && !clear;
        cnt_d    = cnt_q + PPT_PRESC_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ppt_controller.sv
// PPT firing controller: latches a run configuration and emits count pulses.
// Optional registered charge output is built when PPT_CHARGE_EN is defined.
module ppt_controller
    import ppt_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PPT_CLKDIV_W-1:0] clk_div,
    input  logic [PPT_PERIOD_W-1:0] period,
    input  logic [PPT_PERIOD_W-1:0] width,
    input  logic [PPT_COUNT_W-1:0]  count,
    input  logic                    run_ppt,
`ifdef PPT_CHARGE_EN
    output logic                    charge,
`endif
    output logic                    pulse,
    output logic [PPT_COUNT_W-1:0]  count_done,
    output logic                    done
);

    ppt_state_e              state_q, state_d;
    ppt_cfg_t                cfg_q, cfg_d;
    logic [PPT_PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [PPT_COUNT_W-1:0]  count_done_q, count_done_d;
    logic                    pulse_q, pulse_d;
    logic                    done_q, done_d;
    logic [PPT_PERIOD_W-1:0] eff_p_q, eff_w_d;
    logic                    pulse_cond;
    logic                    tick;

    ppt_prescaler u_presc (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != FIRE),
        .clk_div (cfg_q.clk_div),
        .tick    (tick)
    );

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        tick_cnt_d   = tick_cnt_q;
        count_done_d = count_done_q;
        eff_p_q      = eff_period(cfg_q.period);

        unique case (state_q)
            IDLE: begin
                if (run_ppt) begin
                    cfg_d        = '{clk_div: clk_div, period: period, width: width, count: count};
                    count_done_d = '0;
                    tick_cnt_d   = '0;
                    state_d      = FIRE;
                end
            end
            FIRE: begin
                // Abort wins over a firing that would complete on this same edge
                if (!run_ppt) begin
                    state_d = IDLE;
                end else if (cfg_q.count == '0) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (tick_cnt_q == eff_p_q - PPT_PERIOD_W'(1)) begin
                        tick_cnt_d   = '0;
                        count_done_d = count_done_q + PPT_COUNT_W'(1);
                        if (count_done_d == cfg_q.count) begin
                            state_d = DONE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + PPT_PERIOD_W'(1);
                    end
                end
            end
            DONE: begin
                if (!run_ppt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next-state values so the flops line up with the state
        eff_w_d    = eff_width(cfg_d.width, cfg_d.period);
        pulse_cond = (cfg_d.count != '0) && (tick_cnt_d < eff_w_d);
        pulse_d    = (state_d == FIRE) && pulse_cond;
        done_d     = (state_d == DONE);
    end

`ifdef PPT_CHARGE_EN
    logic charge_q;
    logic charge_d;
    assign charge_d = (state_d == FIRE) && !pulse_cond;
    assign charge   = charge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            charge_q <= 1'b0;
        end else begin
            charge_q <= charge_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            tick_cnt_q   <= '0;
            count_done_q <= '0;
            pulse_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            tick_cnt_q   <= tick_cnt_d;
            count_done_q <= count_done_d;
            pulse_q      <= pulse_d;
            done_q       <= done_d;
        end
    end

    assign pulse      = pulse_q;
    assign count_done = count_done_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ppt_controller.sv
// Bench for ppt_controller: directed scenarios plus random stimulus against a cycle-level model.
module tb_ppt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  clk_div;
    logic [14:0] period;
    logic [14:0] width;
    logic [7:0]  count;
    logic        run_ppt;
    logic        pulse;
    logic [7:0]  count_done;
    logic        done;
`ifdef PPT_CHARGE_EN
    logic        charge;
`endif

    int checks   = 0;
    int failures = 0;

    ppt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .period     (period),
        .width      (width),
        .count      (count),
        .run_ppt    (run_ppt),
`ifdef PPT_CHARGE_EN
        .charge     (charge),
`endif
        .pulse      (pulse),
        .count_done (count_done),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: time measured in clock cycles since the firing began
    int     m_state;   // 0 idle, 1 firing, 2 done
    longint m_cyc;
    int     m_cd;
    int     m_div, m_per, m_wid, m_cnt;
    logic   exp_pulse, exp_done;

    function automatic longint cyc_per_tick();
        return longint'(1) << (m_div + 1);
    endfunction

    task automatic model_step();
        longint ep, ew;
        if (rst) begin
            m_state = 0; m_cyc = 0; m_cd = 0;
            m_div = 0; m_per = 0; m_wid = 0; m_cnt = 0;
        end else begin
            ep = (m_per == 0) ? 1 : m_per;
            case (m_state)
                0: if (run_ppt) begin
                    m_div = clk_div; m_per = period; m_wid = width; m_cnt = count;
                    m_cd = 0; m_cyc = 0; m_state = 1;
                end
                1: if (!run_ppt) m_state = 0;
                   else if (m_cnt == 0) m_state = 2;
                   else begin
                       m_cyc++;
                       if (m_cyc == ep * cyc_per_tick()) begin
                           m_cyc = 0;
                           m_cd++;
                           if (m_cd == m_cnt) m_state = 2;
                       end
                   end
                default: if (!run_ppt) m_state = 0;
            endcase
        end
        ep = (m_per == 0) ? 1 : m_per;
        ew = (m_wid < ep) ? m_wid : ep;
        exp_pulse = (m_state == 1) && (m_cnt != 0) && (m_cyc < ew * cyc_per_tick());
        exp_done  = (m_state == 2);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_val({tag, "_pulse"}, 32'(pulse), 32'(exp_pulse));
        check_val({tag, "_count_done"}, 32'(count_done), 32'(m_cd));
        check_val({tag, "_done"}, 32'(done), 32'(exp_done));
`ifdef PPT_CHARGE_EN
        check_val({tag, "_charge"}, 32'(charge), 32'((m_state == 1) && !exp_pulse));
`endif
    endtask

    task automatic set_cfg(input int d, input int p, input int w, input int c);
        clk_div = 5'(d); period = 15'(p); width = 15'(w); count = 8'(c);
    endtask

    int first_done, pulse_hi, rises;
    logic prev_pulse;

    initial begin
        rst = 1'b1; run_ppt = 1'b0;
        set_cfg(0, 0, 0, 0);
        m_state = 0; m_cyc = 0; m_cd = 0; m_div = 0; m_per = 0; m_wid = 0; m_cnt = 0;
        step("reset");
        check_val("reset_pulse_zero", 32'(pulse), 32'd0);
        rst = 1'b0;
        step("idle");

        // Nominal run
        set_cfg(0, 4, 1, 3);
        run_ppt = 1'b1;
        first_done = 0; pulse_hi = 0; rises = 0; prev_pulse = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            step("nominal");
            if (done && first_done == 0) first_done = n;
            if (pulse) pulse_hi++;
            if (pulse && !prev_pulse) rises++;
            prev_pulse = pulse;
        end
        check_val("nominal_done_cycle", 32'(first_done), 32'd25);
        check_val("nominal_pulse_cycles", 32'(pulse_hi), 32'd6);
        check_val("nominal_pulse_count", 32'(rises), 32'd3);
        check_val("nominal_count_done", 32'(count_done), 32'd3);

        // Oversized width keeps pulse high for the whole run
        run_ppt = 1'b0; step("rearm");
        set_cfg(0, 4, 10, 2); run_ppt = 1'b1;
        for (int n = 0; n < 20; n++) step("wide");

        // count=0
        run_ppt = 1'b0; step("rearm");
        set_cfg(0, 4, 2, 0); run_ppt = 1'b1;
        step("cnt0");
        check_val("cnt0_done_early", 32'(done), 32'd0);
        step("cnt0");
        check_val("cnt0_done_at_2", 32'(done), 32'd1);
        check_val("cnt0_no_pulse", 32'(pulse), 32'd0);

        // Abort during the second firing, then restart
        run_ppt = 1'b0; step("rearm");
        set_cfg(0, 4, 2, 5); run_ppt = 1'b1;
        for (int n = 0; n < 11; n++) step("abort_run");
        run_ppt = 1'b0;
        step("abort");
        check_val("abort_pulse", 32'(pulse), 32'd0);
        check_val("abort_count_done", 32'(count_done), 32'd1);
        check_val("abort_done", 32'(done), 32'd0);
        run_ppt = 1'b1;
        step("restart");
        check_val("restart_count_done", 32'(count_done), 32'd0);

        // Mid-run config changes ignored; DONE held while run_ppt stays 1
        run_ppt = 1'b0; step("rearm");
        set_cfg(1, 3, 1, 2); run_ppt = 1'b1;
        for (int n = 0; n < 5; n++) step("midchg");
        set_cfg(0, 7, 5, 9);
        for (int n = 0; n < 40; n++) step("midchg");
        check_val("midchg_done_held", 32'(done), 32'd1);

        // Reset while pulse is high, then restart with run_ppt held
        run_ppt = 1'b0; step("rearm");
        set_cfg(0, 4, 3, 4); run_ppt = 1'b1;
        for (int n = 0; n < 3; n++) step("rstpulse");
        check_val("rstpulse_pre_high", 32'(pulse), 32'd1);
        rst = 1'b1;
        step("rstpulse");
        check_val("rstpulse_pulse0", 32'(pulse), 32'd0);
        rst = 1'b0;
        step("rstpulse_restart");
        check_val("rstpulse_restarted", 32'(pulse), 32'd1);

        // Longest divider: no tick within the sampled window
        run_ppt = 1'b0; step("rearm");
        set_cfg(31, 1, 1, 1); run_ppt = 1'b1;
        for (int n = 0; n < 1000; n++) step("div31");
        check_val("div31_no_tick", 32'(count_done), 32'd0);

        // count_done saturates at the largest count
        run_ppt = 1'b0; step("rearm");
        set_cfg(0, 1, 1, 255); run_ppt = 1'b1;
        for (int n = 0; n < 515; n++) step("cnt255");
        check_val("cnt255_final", 32'(count_done), 32'd255);

        // Random stimulus
        set_cfg($urandom_range(2), $urandom_range(5), $urandom_range(6), $urandom_range(4));
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(39) == 0) run_ppt = ~run_ppt;
            if ($urandom_range(9) == 0)
                set_cfg($urandom_range(2), $urandom_range(5), $urandom_range(6), $urandom_range(4));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
